// File: rtl/iir_pkg.sv
// Shared Q-format constants, widths and the output saturation helper for iir_filter16.
// Purely combinational helpers; no state, no flow control.
package iir_pkg;

  localparam int FRAC_BITS = 15;
  localparam int ROUND     = 1 << 14;
  localparam int SAMPLE_W  = 16;
  localparam int PROD_W    = 32;
  localparam int SAT_IN_W  = 48;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAT_IN_W-1:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > 48'sd32767)
      r = 16'sh7fff;
    else if (v < -48'sd32768)
      r = 16'sh8000;
    else
      r = v[SAMPLE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/iir_mac.sv
// N-term signed dot product of a packed sample history with packed coefficients.
// Combinational, zero latency; no flow control.
module iir_mac
  import iir_pkg::*;
#(
  parameter int N_order = 4,
  parameter int Width   = 16,
  parameter int ACC_W   = 36
) (
  input  logic [N_order*SAMPLE_W-1:0] hist,
  input  logic [N_order*Width-1:0]    coef,
  output logic signed [ACC_W-1:0]     sum
);

  localparam int P_W = SAMPLE_W + Width;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc;

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int k = 0; k < N_order; k++) begin
      prod = $signed(hist[SAMPLE_W*k +: SAMPLE_W]) * $signed(coef[Width*k +: Width]);
      acc  = acc + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    end
  end

  assign sum = acc;

endmodule

// File: rtl/iir_filter16.sv
// Direct-form-I IIR filter, one 16-bit sample per clock, Q1.15 coefficients.
// One register stage of latency; no handshake, every edge consumes a sample.
module iir_filter16
  import iir_pkg::*;
#(
  parameter int N_order = 4,
  parameter int Width   = 16
) (
  input  logic                        i_clkp,
  input  logic                        i_rstn,
  input  logic [Width*N_order-1:0]    i_factor_a,
  input  logic [Width*N_order-1:0]    i_factor_b,
  input  logic signed [SAMPLE_W-1:0]  i_filter,
  output logic signed [SAMPLE_W-1:0]  o_filter
);

  localparam int ACC_W = PROD_W + $clog2(2*N_order) + 1;
  localparam int HW    = N_order*SAMPLE_W;

  logic [HW-1:0]           x_vec;
  logic [HW-1:0]           y_hist;
  logic [HW-1:0]           y_shift;
  logic signed [ACC_W-1:0] a_sum;
  logic signed [ACC_W-1:0] b_sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [SAMPLE_W-1:0] y_next;

  // Tap 0 is the live input; older taps come from the N-1 stored samples.
  if (N_order > 1) begin : g_xh
    logic [(N_order-1)*SAMPLE_W-1:0] x_hist;
    always_ff @(posedge i_clkp or negedge i_rstn) begin
      if (!i_rstn)
        x_hist <= '0;
      else
        x_hist <= x_vec[(N_order-1)*SAMPLE_W-1:0];
    end
    assign x_vec = {x_hist, i_filter};
  end else begin : g_xh0
    assign x_vec = i_filter;
  end

  iir_mac #(.N_order(N_order), .Width(Width), .ACC_W(ACC_W)) u_mac_a (
    .hist (x_vec),
    .coef (i_factor_a),
    .sum  (a_sum)
  );

  iir_mac #(.N_order(N_order), .Width(Width), .ACC_W(ACC_W)) u_mac_b (
    .hist (y_hist),
    .coef (i_factor_b),
    .sum  (b_sum)
  );

  // Saturate before the result re-enters the feedback history.
  always_comb begin
    acc     = a_sum + b_sum + ACC_W'(ROUND);
    shifted = acc >>> FRAC_BITS;
    y_next  = sat16({{(SAT_IN_W-ACC_W){shifted[ACC_W-1]}}, shifted});
    y_shift = y_hist << SAMPLE_W;
    y_shift[SAMPLE_W-1:0] = y_next;
  end

  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn)
      y_hist <= '0;
    else
      y_hist <= y_shift;
  end

  assign o_filter = y_hist[SAMPLE_W-1:0];

endmodule

// File: tb/tb_iir_filter16.sv
// Directed bench for iir_filter16: impulse, step, delay, saturation, reset and live coefficient change.
module tb_iir_filter16;

  localparam int N = 4;
  localparam int W = 16;

  logic              i_clkp;
  logic              i_rstn;
  logic [W*N-1:0]    i_factor_a;
  logic [W*N-1:0]    i_factor_b;
  logic signed [15:0] i_filter;
  logic signed [15:0] o_filter;

  int n_checks;
  int n_fail;

  iir_filter16 #(.N_order(N), .Width(W)) dut (
    .i_clkp     (i_clkp),
    .i_rstn     (i_rstn),
    .i_factor_a (i_factor_a),
    .i_factor_b (i_factor_b),
    .i_filter   (i_filter),
    .o_filter   (o_filter)
  );

  initial begin
    i_clkp = 1'b0;
    forever #5 i_clkp = ~i_clkp;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_coef(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] b0);
    i_factor_a = {16'd0, 16'd0, a1, a0};
    i_factor_b = {16'd0, 16'd0, 16'd0, b0};
  endtask

  // Advance one edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge i_clkp);
    #1;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    #2;
    i_rstn = 1'b1;
  endtask

  task automatic run_seq(input string tag, input logic signed [15:0] x, input int exp[]);
    i_filter = x;
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      chk($sformatf("%s[%0d]", tag, i), o_filter, exp[i]);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    i_rstn     = 1'b0;
    i_filter   = '0;
    i_factor_a = '0;
    i_factor_b = '0;
    #12;
    chk("reset_out", o_filter, 0);
    i_rstn = 1'b1;
    tick();

    // Impulse response
    set_coef(16'd30000, 16'd0, 16'd2768);
    run_seq("impulse", 16'sd16384, '{15000});
    run_seq("impulse_tail", 16'sd0, '{1267, 107, 9, 1, 0, 0});

    // Step response then live coefficient swap with the same DC gain
    do_reset();
    run_seq("step", 16'sd1000, '{916, 993, 999, 1000, 1000, 1000, 1000});
    set_coef(16'd16384, 16'd0, 16'd16384);
    run_seq("live_coef", 16'sd1000, '{1000, 1000, 1000, 1000});

    // Asynchronous reset in the middle of a step
    set_coef(16'd30000, 16'd0, 16'd2768);
    do_reset();
    run_seq("pre_rst", 16'sd1000, '{916, 993});
    #2;
    i_rstn = 1'b0;
    #1;
    chk("mid_reset_out", o_filter, 0);
    i_rstn = 1'b1;
    run_seq("post_rst", 16'sd1000, '{916, 993, 999, 1000});

    // Pure one-sample delay at half gain
    do_reset();
    set_coef(16'd0, 16'd16384, 16'd0);
    run_seq("delay", 16'sd1000, '{0});
    run_seq("delay_tail", 16'sd0, '{500, 0});

    // Saturation in both directions
    do_reset();
    set_coef(16'd32767, 16'd32767, 16'd0);
    run_seq("sat_pos", 16'sd32767, '{32766, 32767, 32767});
    run_seq("sat_neg", -16'sd32768, '{-1, -32768, -32768});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
